// File: rtl/colour_lut_pkg.sv
// Shared types and constants for the colour LUT arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package colour_lut_pkg;

   localparam int LUT_ADDR_W = 3;
   localparam int LUT_DATA_W = 24;

   localparam logic ID_REQ0 = 1'b0;
   localparam logic ID_REQ1 = 1'b1;

   // One tag per granted read, travelling alongside the BRAM read latency.
   typedef struct packed {
      logic vld;
      logic id;
   } rsp_tag_t;

endpackage

// File: rtl/colour_lut_rsp_pipe.sv
// Read-response pipeline: delays a {vld,id} tag by RD_LATENCY and captures mem_dout for the tagged requester.
// Latency: rsp pulse RD_LATENCY+1 cycles after the grant cycle.
// Backpressure: none, one response per granted read, back-to-back capable.
// Ports: clk/rst_n (sync, active low), gnt_tag_i (tag of this cycle's read grant),
//        mem_dout_i (BRAM douta), rsp0/rsp1 valid pulse + held data.
module colour_lut_rsp_pipe
   import colour_lut_pkg::*;
#(
   parameter int DATA_W     = LUT_DATA_W,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  rsp_tag_t          gnt_tag_i,
   input  logic [DATA_W-1:0] mem_dout_i,
   output logic              rsp0_valid_o,
   output logic [DATA_W-1:0] rsp0_data_o,
   output logic              rsp1_valid_o,
   output logic [DATA_W-1:0] rsp1_data_o
);

   rsp_tag_t          tag_q [RD_LATENCY];
   rsp_tag_t          tag_out;
   logic              hit0;
   logic              hit1;
   logic              rsp0_valid_q;
   logic              rsp1_valid_q;
   logic [DATA_W-1:0] rsp0_data_q;
   logic [DATA_W-1:0] rsp1_data_q;

   // The tag leaving the last stage lines up with the cycle douta is valid.
   assign tag_out = tag_q[RD_LATENCY-1];
   assign hit0    = tag_out.vld && (tag_out.id == ID_REQ0);
   assign hit1    = tag_out.vld && (tag_out.id == ID_REQ1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
      end else begin
         tag_q[0] <= gnt_tag_i;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
         rsp0_valid_q <= hit0;
         rsp1_valid_q <= hit1;
         if (hit0) begin
            rsp0_data_q <= mem_dout_i;
         end
         if (hit1) begin
            rsp1_data_q <= mem_dout_i;
         end
      end
   end

   assign rsp0_valid_o = rsp0_valid_q;
   assign rsp1_valid_o = rsp1_valid_q;
   assign rsp0_data_o  = rsp0_data_q;
   assign rsp1_data_o  = rsp1_data_q;

endmodule

// File: rtl/colour_lut_arbiter.sv
// Arbitrates one single-port colour LUT BRAM between two readers and one config writer.
// Latency: grant is combinational; read response RD_LATENCY+1 cycles after handshake.
// Backpressure: readies are combinational; cfg has priority but yields one read after MAX_CFG_RUN grants.
// Ports: req0/req1 read request + response, cfg write request, mem_* drive the BRAM port A.
module colour_lut_arbiter
   import colour_lut_pkg::*;
#(
   parameter int ADDR_W      = LUT_ADDR_W,
   parameter int DATA_W      = LUT_DATA_W,
   parameter int RD_LATENCY  = 1,
   parameter int MAX_CFG_RUN = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_data,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_data,
   input  logic              cfg_valid,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   output logic              cfg_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam int RUN_W = $clog2(MAX_CFG_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CFG_RUN);

   logic             rr_q, rr_d;
   logic [RUN_W-1:0] cfg_run_q, cfg_run_d;

   logic     any_rd;
   logic     force_rd;
   logic     gnt_cfg;
   logic     gnt_rd;
   logic     rd_id;
   rsp_tag_t gnt_tag;

   always_comb begin
      any_rd   = req0_valid || req1_valid;
      // A long cfg burst must not starve readers: once the run limit is hit, a read goes first.
      force_rd = any_rd && (cfg_run_q == RUN_MAX);
      // Grants are qualified by rst_n so nothing is accepted while reset is asserted.
      gnt_cfg  = rst_n && cfg_valid && !force_rd;
      gnt_rd   = rst_n && any_rd && !gnt_cfg;
      // Both valid: pointer decides; otherwise whichever one is valid.
      rd_id    = (req0_valid && req1_valid) ? rr_q : req1_valid;

      cfg_ready  = gnt_cfg;
      req0_ready = gnt_rd && (rd_id == ID_REQ0);
      req1_ready = gnt_rd && (rd_id == ID_REQ1);

      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      if (gnt_cfg) begin
         mem_en   = 1'b1;
         mem_we   = 1'b1;
         mem_addr = cfg_addr;
         mem_din  = cfg_data;
      end else if (gnt_rd) begin
         mem_en   = 1'b1;
         mem_addr = (rd_id == ID_REQ1) ? req1_addr : req0_addr;
      end

      gnt_tag.vld = gnt_rd;
      gnt_tag.id  = rd_id;

      rr_d = gnt_rd ? ~rd_id : rr_q;

      cfg_run_d = cfg_run_q;
      if (!any_rd || gnt_rd) begin
         cfg_run_d = '0;
      end else if (gnt_cfg && (cfg_run_q != RUN_MAX)) begin
         cfg_run_d = cfg_run_q + RUN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_q      <= 1'b0;
         cfg_run_q <= '0;
      end else begin
         rr_q      <= rr_d;
         cfg_run_q <= cfg_run_d;
      end
   end

   colour_lut_rsp_pipe #(
      .DATA_W     (DATA_W),
      .RD_LATENCY (RD_LATENCY)
   ) u_rsp_pipe (
      .clk          (clk),
      .rst_n        (rst_n),
      .gnt_tag_i    (gnt_tag),
      .mem_dout_i   (mem_dout),
      .rsp0_valid_o (rsp0_valid),
      .rsp0_data_o  (rsp0_data),
      .rsp1_valid_o (rsp1_valid),
      .rsp1_data_o  (rsp1_data)
   );

endmodule

// File: tb/tb_colour_lut_arbiter.sv
// Directed bench for colour_lut_arbiter: one instance at RD_LATENCY=1, one at RD_LATENCY=2,
// each with its own behavioural BRAM of matching latency.
module tb_colour_lut_arbiter;

   localparam logic [23:0] BLU  = 24'h0000FF;
   localparam logic [23:0] GRN  = 24'h00FF00;
   localparam logic [23:0] MAG  = 24'hFF00FF;
   localparam logic [23:0] ABC  = 24'hABCDEF;
   localparam logic [23:0] ONE  = 24'h111111;
   localparam logic [23:0] FOUR = 24'h444444;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- DUT A: RD_LATENCY = 1 ----------------
   logic        req0_valid, req1_valid, cfg_valid;
   logic [2:0]  req0_addr, req1_addr, cfg_addr;
   logic [23:0] cfg_data;
   logic        req0_ready, req1_ready, cfg_ready;
   logic        rsp0_valid, rsp1_valid;
   logic [23:0] rsp0_data, rsp1_data;
   logic        mem_en, mem_we;
   logic [2:0]  mem_addr;
   logic [23:0] mem_din, mem_dout;

   colour_lut_arbiter #(.ADDR_W(3), .DATA_W(24), .RD_LATENCY(1), .MAX_CFG_RUN(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
      .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   logic [23:0] ram_a [8];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram_a[mem_addr] <= mem_din;
         else        mem_dout <= ram_a[mem_addr];
      end
   end

   // ---------------- DUT B: RD_LATENCY = 2 ----------------
   logic        b_req0_valid, b_req1_valid, b_cfg_valid;
   logic [2:0]  b_req0_addr, b_req1_addr, b_cfg_addr;
   logic [23:0] b_cfg_data;
   logic        b_req0_ready, b_req1_ready, b_cfg_ready;
   logic        b_rsp0_valid, b_rsp1_valid;
   logic [23:0] b_rsp0_data, b_rsp1_data;
   logic        b_mem_en, b_mem_we;
   logic [2:0]  b_mem_addr;
   logic [23:0] b_mem_din, b_mem_dout, b_rd_stage;

   colour_lut_arbiter #(.ADDR_W(3), .DATA_W(24), .RD_LATENCY(2), .MAX_CFG_RUN(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(b_req0_valid), .req0_addr(b_req0_addr), .req0_ready(b_req0_ready),
      .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data),
      .req1_valid(b_req1_valid), .req1_addr(b_req1_addr), .req1_ready(b_req1_ready),
      .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data),
      .cfg_valid(b_cfg_valid), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data), .cfg_ready(b_cfg_ready),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_din(b_mem_din),
      .mem_dout(b_mem_dout)
   );

   logic [23:0] ram_b [8];
   always @(posedge clk) begin
      if (b_mem_en) begin
         if (b_mem_we) ram_b[b_mem_addr] <= b_mem_din;
         else          b_rd_stage <= ram_b[b_mem_addr];
      end
      b_mem_dout <= b_rd_stage;
   end

   // ---------------- vector table ----------------
   typedef struct packed {
      logic        cv;  logic [2:0] ca;  logic [23:0] cd;
      logic        r0v; logic [2:0] r0a;
      logic        r1v; logic [2:0] r1a;
      logic        cr;  logic r0r; logic r1r;
      logic        en;  logic we;  logic [2:0] ma; logic [23:0] md;
      logic        p0v; logic [23:0] p0d;
      logic        p1v; logic [23:0] p1d;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic cv, input logic [2:0] ca, input logic [23:0] cd,
      input logic r0v, input logic [2:0] r0a, input logic r1v, input logic [2:0] r1a,
      input logic cr, input logic r0r, input logic r1r,
      input logic en, input logic we, input logic [2:0] ma, input logic [23:0] md,
      input logic p0v, input logic [23:0] p0d, input logic p1v, input logic [23:0] p1d);
      vec_t v;
      v.cv = cv;   v.ca = ca;   v.cd = cd;
      v.r0v = r0v; v.r0a = r0a; v.r1v = r1v; v.r1a = r1a;
      v.cr = cr;   v.r0r = r0r; v.r1r = r1r;
      v.en = en;   v.we = we;   v.ma = ma;   v.md = md;
      v.p0v = p0v; v.p0d = p0d; v.p1v = p1v; v.p1d = p1d;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_a();
      cfg_valid = 0; cfg_addr = 0; cfg_data = 0;
      req0_valid = 0; req0_addr = 0; req1_valid = 0; req1_addr = 0;
   endtask

   task automatic idle_b();
      b_cfg_valid = 0; b_cfg_addr = 0; b_cfg_data = 0;
      b_req0_valid = 0; b_req0_addr = 0; b_req1_valid = 0; b_req1_addr = 0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         ram_a[i] = '0;
         ram_b[i] = '0;
      end
      mem_dout = '0; b_mem_dout = '0; b_rd_stage = '0;
      idle_a();
      idle_b();

      // idle, preload 1/2/5
      vq.push_back(mk(0,0,0,    0,0,0,0, 0,0,0, 0,0,0,0,    0,0,0,0));
      vq.push_back(mk(1,1,BLU,  0,0,0,0, 1,0,0, 1,1,1,BLU,  0,0,0,0));
      vq.push_back(mk(1,2,GRN,  0,0,0,0, 1,0,0, 1,1,2,GRN,  0,0,0,0));
      vq.push_back(mk(1,5,MAG,  0,0,0,0, 1,0,0, 1,1,5,MAG,  0,0,0,0));
      // round-robin from reset: 0,1,0,1
      vq.push_back(mk(0,0,0,    1,1,1,2, 0,1,0, 1,0,1,0,    0,0,0,0));
      vq.push_back(mk(0,0,0,    1,1,1,2, 0,0,1, 1,0,2,0,    0,0,0,0));
      vq.push_back(mk(0,0,0,    1,1,1,2, 0,1,0, 1,0,1,0,    1,BLU,0,0));
      vq.push_back(mk(0,0,0,    1,1,1,2, 0,0,1, 1,0,2,0,    0,BLU,1,GRN));
      vq.push_back(mk(0,0,0,    1,5,0,0, 0,1,0, 1,0,5,0,    1,BLU,0,GRN));
      // idle: mem quiet, data held
      vq.push_back(mk(0,0,0,    0,0,0,0, 0,0,0, 0,0,0,0,    0,BLU,1,GRN));
      vq.push_back(mk(0,0,0,    0,0,0,0, 0,0,0, 0,0,0,0,    1,MAG,0,GRN));
      vq.push_back(mk(0,0,0,    0,0,0,0, 0,0,0, 0,0,0,0,    0,MAG,0,GRN));
      // write then read next cycle
      vq.push_back(mk(1,5,ABC,  0,0,0,0, 1,0,0, 1,1,5,ABC,  0,MAG,0,GRN));
      vq.push_back(mk(0,0,0,    1,5,0,0, 0,1,0, 1,0,5,0,    0,MAG,0,GRN));
      vq.push_back(mk(0,0,0,    0,0,0,0, 0,0,0, 0,0,0,0,    0,MAG,0,GRN));
      vq.push_back(mk(0,0,0,    0,0,0,0, 0,0,0, 0,0,0,0,    1,ABC,0,GRN));
      // cfg + two reads: cfg first, then rr=1 picks req1, then req0
      vq.push_back(mk(1,3,ONE,  1,3,1,2, 1,0,0, 1,1,3,ONE,  0,ABC,0,GRN));
      vq.push_back(mk(0,0,0,    1,3,1,2, 0,0,1, 1,0,2,0,    0,ABC,0,GRN));
      vq.push_back(mk(0,0,0,    1,3,0,0, 0,1,0, 1,0,3,0,    0,ABC,0,GRN));
      // two idles keep rr=1, so next contended read goes to req1
      vq.push_back(mk(0,0,0,    0,0,0,0, 0,0,0, 0,0,0,0,    0,ABC,1,GRN));
      vq.push_back(mk(0,0,0,    0,0,0,0, 0,0,0, 0,0,0,0,    1,ONE,0,GRN));
      vq.push_back(mk(0,0,0,    1,1,1,2, 0,0,1, 1,0,2,0,    0,ONE,0,GRN));
      vq.push_back(mk(0,0,0,    1,1,0,0, 0,1,0, 1,0,1,0,    0,ONE,0,GRN));
      // starvation guard: 4 cfg, 1 read, 4 cfg, 1 read
      vq.push_back(mk(1,4,FOUR, 0,0,1,2, 1,0,0, 1,1,4,FOUR, 0,ONE,1,GRN));
      vq.push_back(mk(1,4,FOUR, 0,0,1,2, 1,0,0, 1,1,4,FOUR, 1,BLU,0,GRN));
      vq.push_back(mk(1,4,FOUR, 0,0,1,2, 1,0,0, 1,1,4,FOUR, 0,BLU,0,GRN));
      vq.push_back(mk(1,4,FOUR, 0,0,1,2, 1,0,0, 1,1,4,FOUR, 0,BLU,0,GRN));
      vq.push_back(mk(1,4,FOUR, 0,0,1,2, 0,0,1, 1,0,2,0,    0,BLU,0,GRN));
      vq.push_back(mk(1,4,FOUR, 0,0,1,2, 1,0,0, 1,1,4,FOUR, 0,BLU,0,GRN));
      vq.push_back(mk(1,4,FOUR, 0,0,1,2, 1,0,0, 1,1,4,FOUR, 0,BLU,1,GRN));
      vq.push_back(mk(1,4,FOUR, 0,0,1,2, 1,0,0, 1,1,4,FOUR, 0,BLU,0,GRN));
      vq.push_back(mk(1,4,FOUR, 0,0,1,2, 1,0,0, 1,1,4,FOUR, 0,BLU,0,GRN));
      vq.push_back(mk(1,4,FOUR, 0,0,1,2, 0,0,1, 1,0,2,0,    0,BLU,0,GRN));
      vq.push_back(mk(0,0,0,    0,0,0,0, 0,0,0, 0,0,0,0,    0,BLU,0,GRN));
      vq.push_back(mk(0,0,0,    0,0,0,0, 0,0,0, 0,0,0,0,    0,BLU,1,GRN));

      // ---------------- reset state ----------------
      cyc(); cyc();
      smp();
      chk("rst_cfg_ready", 0, 32'(cfg_ready), 0);
      chk("rst_req0_ready", 0, 32'(req0_ready), 0);
      chk("rst_mem_en", 0, 32'(mem_en), 0);
      chk("rst_rsp0_valid", 0, 32'(rsp0_valid), 0);
      chk("rst_rsp0_data", 0, 32'(rsp0_data), 0);
      chk("rst_rsp1_data", 0, 32'(rsp1_data), 0);

      // ---------------- table ----------------
      foreach (vq[i]) begin
         cyc();
         rst_n = 1'b1;
         cfg_valid = vq[i].cv;   cfg_addr = vq[i].ca;   cfg_data = vq[i].cd;
         req0_valid = vq[i].r0v; req0_addr = vq[i].r0a;
         req1_valid = vq[i].r1v; req1_addr = vq[i].r1a;
         smp();
         chk("cfg_ready",  i, 32'(cfg_ready),  32'(vq[i].cr));
         chk("req0_ready", i, 32'(req0_ready), 32'(vq[i].r0r));
         chk("req1_ready", i, 32'(req1_ready), 32'(vq[i].r1r));
         chk("mem_en",     i, 32'(mem_en),     32'(vq[i].en));
         chk("mem_we",     i, 32'(mem_we),     32'(vq[i].we));
         chk("mem_addr",   i, 32'(mem_addr),   32'(vq[i].ma));
         chk("mem_din",    i, 32'(mem_din),    32'(vq[i].md));
         chk("rsp0_valid", i, 32'(rsp0_valid), 32'(vq[i].p0v));
         chk("rsp0_data",  i, 32'(rsp0_data),  32'(vq[i].p0d));
         chk("rsp1_valid", i, 32'(rsp1_valid), 32'(vq[i].p1v));
         chk("rsp1_data",  i, 32'(rsp1_data),  32'(vq[i].p1d));
      end

      // ---------------- reset mid-flight ----------------
      // cycle k: req0 accepted (rr moves to 1)
      cyc(); idle_a(); req0_valid = 1; req0_addr = 1;
      smp(); chk("mf_k_req0_ready", 100, 32'(req0_ready), 1);
      // k+1: reset asserted, requests still presented
      cyc(); rst_n = 1'b0; req1_valid = 1; req1_addr = 2;
      smp();
      chk("mf_k1_req0_ready", 101, 32'(req0_ready), 0);
      chk("mf_k1_req1_ready", 101, 32'(req1_ready), 0);
      chk("mf_k1_mem_en",     101, 32'(mem_en), 0);
      chk("mf_k1_mem_addr",   101, 32'(mem_addr), 0);
      chk("mf_k1_rsp0_valid", 101, 32'(rsp0_valid), 0);
      // k+2: still in reset, everything cleared
      cyc(); idle_a();
      smp();
      chk("mf_k2_rsp0_valid", 102, 32'(rsp0_valid), 0);
      chk("mf_k2_rsp0_data",  102, 32'(rsp0_data), 0);
      chk("mf_k2_rsp1_data",  102, 32'(rsp1_data), 0);
      // k+3, k+4: released, the dropped read must not reappear
      cyc(); rst_n = 1'b1;
      smp();
      chk("mf_k3_rsp0_valid", 103, 32'(rsp0_valid), 0);
      chk("mf_k3_mem_en",     103, 32'(mem_en), 0);
      cyc();
      smp();
      chk("mf_k4_rsp0_valid", 104, 32'(rsp0_valid), 0);
      chk("mf_k4_rsp0_data",  104, 32'(rsp0_data), 0);
      // rr back to 0: contended read goes to req0
      cyc(); req0_valid = 1; req0_addr = 1; req1_valid = 1; req1_addr = 2;
      smp();
      chk("mf_rr_req0_ready", 105, 32'(req0_ready), 1);
      chk("mf_rr_req1_ready", 105, 32'(req1_ready), 0);
      cyc(); idle_a();

      // ---------------- RD_LATENCY = 2 ----------------
      cyc(); b_cfg_valid = 1; b_cfg_addr = 7; b_cfg_data = 24'h123456;
      smp();
      chk("l2_cfg_ready", 200, 32'(b_cfg_ready), 1);
      chk("l2_mem_we",    200, 32'(b_mem_we), 1);
      cyc(); idle_b(); b_req0_valid = 1; b_req0_addr = 7;
      smp();
      chk("l2_req0_ready", 201, 32'(b_req0_ready), 1);
      chk("l2_mem_addr",   201, 32'(b_mem_addr), 7);
      cyc(); idle_b(); b_req1_valid = 1; b_req1_addr = 7;
      smp();
      chk("l2_req1_ready", 202, 32'(b_req1_ready), 1);
      chk("l2_p0v_k1",     202, 32'(b_rsp0_valid), 0);
      cyc(); idle_b();
      smp();
      chk("l2_p0v_k2", 203, 32'(b_rsp0_valid), 0);
      chk("l2_p1v_k1", 203, 32'(b_rsp1_valid), 0);
      cyc();
      smp();
      chk("l2_p0v_k3", 204, 32'(b_rsp0_valid), 1);
      chk("l2_p0d_k3", 204, 32'(b_rsp0_data), 32'h123456);
      chk("l2_p1v_k2", 204, 32'(b_rsp1_valid), 0);
      cyc();
      smp();
      chk("l2_p1v_k3", 205, 32'(b_rsp1_valid), 1);
      chk("l2_p1d_k3", 205, 32'(b_rsp1_data), 32'h123456);
      chk("l2_p0v_end", 205, 32'(b_rsp0_valid), 0);
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/colour_lut_arbiter.md
Name: colour_lut_arbiter

Overview:
- Shares the single-port 8-entry × 24-bit colour lookup BRAM between two read requesters and one configuration (write) requester.
- Grants at most one BRAM access per cycle and drives the BRAM port directly.
- Returns read data to the correct requester with fixed latency.
- Sits between the colour-converter users (e.g. two display channels) and the colour lookup memory instance.

Parameters:
- ADDR_W, 3: BRAM address width (entries = 2**ADDR_W).
- DATA_W, 24: RGB word width.
- RD_LATENCY, 1: BRAM clock edges from address capture to valid douta. Legal values are 1 or 2.
- MAX_CFG_RUN, 4: consecutive cfg grants allowed while any read is pending before one read is forced through.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- req0_valid  in  1  read request, requester 0
- req0_addr  in  ADDR_W  read address, requester 0
- req0_ready  out  1  request 0 accepted this cycle
- rsp0_valid  out  1  one-cycle pulse: rsp0_data updated
- rsp0_data  out  DATA_W  read data, requester 0 (held between pulses)
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data: as above, requester 1
- cfg_valid  in  1  write request
- cfg_addr  in  ADDR_W  write address
- cfg_data  in  DATA_W  write data
- cfg_ready  out  1  write accepted this cycle
- mem_en  out  1  to BRAM ena
- mem_we  out  1  to BRAM wea
- mem_addr  out  ADDR_W  to BRAM addra
- mem_din  out  DATA_W  to BRAM dina
- mem_dout  in  DATA_W  from BRAM douta

Behaviour:
- **Clocking and reset:** one clock domain (clk); reset is synchronous and active-low (rst_n).
- **Handshake:** a transfer occurs on valid && ready. Readies are combinational from the valids and the arbiter state. At most one ready is high per cycle. Requesters hold valid, addr and data stable until accepted.
- **Grant priority, per cycle:**
  - cfg wins, unless cfg_run == MAX_CFG_RUN and some read is valid. In that case a read is granted and cfg_ready = 0.
  - Otherwise reads are granted round-robin via a 1-bit pointer rr (0 = requester 0 preferred).
  - If only one read is valid, it is granted regardless of rr.
  - rr toggles to the non-granted requester after each read grant and is unchanged otherwise.
- **cfg_run counter:**
  - Increments on each cfg grant while a read is valid.
  - Saturates at MAX_CFG_RUN.
  - Clears on any read grant, or on any cycle with no read valid.
- **BRAM drive:** combinational from the grant.
  - cfg grant: mem_en = 1, mem_we = 1, mem_addr = cfg_addr, mem_din = cfg_data.
  - Read grant: mem_en = 1, mem_we = 0, mem_addr = reqN_addr, mem_din = 0.
  - No grant: mem_en = 0, mem_we = 0, mem_addr = 0, mem_din = 0.
- **Response pipeline:**
  - A RD_LATENCY-deep shift register carries {valid, id} per read grant.
  - When the tag emerges, mem_dout is registered into rspN_data, and rspN_valid pulses high for one cycle in the same cycle the new data appears.
  - Total latency is RD_LATENCY+1 cycles: a handshake in cycle k gives rsp in cycle k+RD_LATENCY+1.
  - Responses have no back-pressure. Back-to-back grants give back-to-back responses.
- **Ordering:** a write accepted in cycle k is visible to a read accepted in cycle k+1 or later. A write and a read are never in the same cycle.
- **Reset (rst_n low at an edge):**
  - All readies = 0, mem_* = 0, rsp*_valid = 0, rsp*_data = 0.
  - rr = 0, cfg_run = 0, pipeline tags cleared.
  - Reset mid-operation drops in-flight reads: no rsp pulse after reset.
- **Boundaries:**
  - Address 7 and address 0 need no special handling.
  - A simultaneous cfg plus two reads resolves per the rules above.
  - An idle cycle leaves rr unchanged.

Decomposition:
- Package colour_lut_pkg: ADDR_W/DATA_W defaults, requester id constants (ID_REQ0 = 0, ID_REQ1 = 1), and the rsp tag struct {logic vld; logic id;}.
- One sub-module: colour_lut_rsp_pipe (tag shift register plus rsp data capture, parameterised by RD_LATENCY).
- The grant logic stays in the top level.

Test Plan:
- **Write then read:** cfg write addr 5 = 24'hFF00FF in cycle 2, req0 read addr 5 in cycle 3 -> cfg_ready = 1 in cycle 2, req0_ready = 1 in cycle 3, rsp0_valid pulse in cycle 5 with rsp0_data = 24'hFF00FF.
- **Round-robin:** req0 and req1 both valid continuously, addrs 1 and 2 preloaded 24'h0000FF / 24'h00FF00 -> grants alternate 0,1,0,1 starting with 0 after reset. rsp0/rsp1 pulses alternate each cycle with the correct data.
- **Starvation guard:** cfg_valid held high 10 cycles with req1_valid high -> 4 cfg grants, 1 req1 grant, 4 cfg grants, 1 req1 grant. mem_we follows 1,1,1,1,0 exactly.
- **Reset mid-flight:** req0 accepted in cycle k, rst_n low in cycle k+1 -> no rsp0_valid in cycles k+1..k+4, all outputs 0. After release, rr = 0.
- **Latency parameter:** RD_LATENCY = 2 with a BRAM model of latency 2, read addr 7 = 24'h123456 -> rsp pulse exactly 3 cycles after the handshake, data correct.
- **Idle:** all valids low -> mem_en = 0, all readies 0, rsp*_data hold their last values.
